emf_scheduler: RTL and testbench
================================

Name: emf_scheduler

Overview:
- Time-multiplexes one shared back-EMF estimation unit across NUM_MOT motor channels on the QLA.
- On each ADC-sample start strobe, snapshots every channel's current command and feedback, then drives the shared unit once per enabled channel in round-robin order.
- Handshakes with the unit's val_ready / emf_ready / emf_overflow signals and collects the results into per-channel output registers for readout by the board register file.

Parameters:
- NUM_MOT, 4, number of motor channels (1..8).
- TMO_CYC, 15, maximum clocks to wait for emf_ready before abandoning a channel (4-bit counter).
- FILT_SHIFT, 3, IIR smoothing shift; used only with EMF_FILTER_EN.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle strobe: new ADC sample set is valid.
- chan_en, in, NUM_MOT, per-channel enable mask, sampled at start.
- cur_cmd_bus, in, 16*NUM_MOT, current commands; channel i is in bits [16i+15:16i].
- cur_fb_bus, in, 16*NUM_MOT, current feedbacks; same packing.
- emf_val_ready, out, 1, trigger to the shared unit.
- emf_cur_cmd, out, 16, selected channel command to the shared unit.
- emf_cur_fb, out, 16, selected channel feedback to the shared unit.
- emf_ready, in, 1, result strobe from the shared unit.
- emf_overflow, in, 1, overflow flag; valid the cycle after emf_ready.
- emf_in, in, 17, signed EMF result from the shared unit.
- emf_bus, out, 17*NUM_MOT, per-channel latched EMF results.
- ovf_flags, out, NUM_MOT, per-channel overflow flags from the last pass.
- tmo_flags, out, NUM_MOT, per-channel timeout flags from the last pass.
- busy, out, 1, high while a pass is in progress.
- done, out, 1, one-cycle pulse when a pass completes.
- overrun_cnt, out, 8, saturating count of start strobes dropped.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output, snapshot register, channel index, pending flag and counter is 0.
- States:
  - IDLE: on start, snapshot cur_cmd_bus, cur_fb_bus and chan_en; clear ovf_flags and tmo_flags; set busy; select the lowest enabled channel. If the mask is 0, go to DONE; otherwise go to ISSUE.
  - ISSUE (1 clk): emf_val_ready=1. emf_cur_cmd and emf_cur_fb carry the selected channel's snapshot and are stable from ISSUE through CAPT. Next state is WAIT.
  - WAIT: emf_val_ready=0; the timeout counter increments each clk. If emf_ready=1, latch emf_in into that channel's emf_bus slice and go to CAPT. If the counter reaches TMO_CYC first, set the tmo_flags bit, leave emf_bus unchanged, and advance to the next channel.
  - CAPT (1 clk): latch emf_overflow into the ovf_flags bit, then advance.
  - Advance: go to ISSUE for the next higher enabled channel, or to DONE if none remain.
  - DONE (1 clk): done=1, busy=0. Go to ISSUE if pending is set (snapshot taken then, pending cleared); otherwise go to IDLE.
- emf_val_ready is low for at least 2 clks between ISSUE pulses, so the shared unit always sees a clean rising edge.
- Nominal latency: 3 clks per enabled channel plus 1 for DONE. For NUM_MOT=4 with all channels enabled, done is high in the 13th cycle after the start-sampling edge.
- A start strobe while busy, or arriving in the DONE cycle, sets pending (one deep). A start while pending is already set increments overrun_cnt, which saturates at 255.
- A stray emf_ready outside WAIT is ignored.
- emf_bus slices of disabled channels hold their old values. Their flags read 0.
- Reset mid-pass aborts immediately; no partial done pulse is issued.

Optional Feature:
- Macro: EMF_FILTER_EN.
- Defined: each channel keeps a 17-bit signed filtered value f, updated in CAPT as f <= f + ((emf_in - f) >>> FILT_SHIFT), computed at 18 bits and saturated to 17. emf_bus carries f, and f resets to 0.
- Undefined: emf_bus carries the raw emf_in and no filter registers exist.

Decomposition:
- Shared package EmfPkg: state encoding localparams (IDLE, ISSUE, WAIT, CAPT, DONE), EMF_W=17, CUR_W=16, and the overrun saturation limit.
- Sub-module emf_chan_sel: combinational next-enabled-channel finder (mask and current index in; next index and none_left out). The FSM and capture registers stay in emf_scheduler.

Test Plan:
- All 4 enabled; a behavioural EMF model returns emf_ready 1 clk after the val_ready rising edge, with emf_in = 100*(i+1) -> emf_bus = {400,300,200,100}, done in cycle 13, 4 val_ready pulses, each ≥2 clks apart.
- chan_en=4'b0101 -> only channels 0 and 2 issued; slices 1 and 3 unchanged; done in cycle 7.
- Model withholds emf_ready for channel 1 -> tmo_flags=4'b0010 after 15 WAIT clks; channels 2 and 3 still captured.
- Overflow model: emf_overflow=1 on channel 3 -> ovf_flags=4'b1000, cleared on the next pass.
- start during a pass, twice -> second pass starts straight from DONE; overrun_cnt=1.
- reset=0 mid-WAIT -> all outputs 0 asynchronously; a later start yields a correct full pass.

Source files
------------

// File: rtl/emf_scheduler_pkg.sv
// rtl/emf_scheduler_pkg.sv - shared types and constants for the EMF scheduler
package EmfPkg;

    localparam int CUR_W = 16;
    localparam int EMF_W = 17;
    localparam logic [7:0] OVR_MAX = 8'd255;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE} state_e;

    // Clamp an 18-bit signed intermediate to the 17-bit EMF range.
    function automatic logic [EMF_W-1:0] sat_emf(input logic [EMF_W:0] v);
        if (v[EMF_W] != v[EMF_W-1]) begin
            return v[EMF_W] ? {1'b1, {(EMF_W-1){1'b0}}} : {1'b0, {(EMF_W-1){1'b1}}};
        end
        return v[EMF_W-1:0];
    endfunction

endpackage

// File: rtl/emf_scheduler_chan_sel.sv
// rtl/emf_scheduler_chan_sel.sv - finds the next enabled channel above (or at) an index
module emf_chan_sel #(
    parameter int NUM_MOT = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_MOT-1:0] mask_i,
    input  logic [IDX_W-1:0]   cur_idx_i,
    input  logic               incl_cur_i,
    output logic [IDX_W-1:0]   nxt_idx_o,
    output logic               none_left_o
);

    // Scan downwards so the last hit is the lowest qualifying channel.
    always_comb begin
        nxt_idx_o   = '0;
        none_left_o = 1'b1;
        for (int i = NUM_MOT - 1; i >= 0; i--) begin
            if (mask_i[i] && ((i > int'(cur_idx_i)) || (incl_cur_i && (i == int'(cur_idx_i))))) begin
                nxt_idx_o   = IDX_W'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/emf_scheduler.sv
// rtl/emf_scheduler.sv - round-robin scheduler for a shared back-EMF unit (option: EMF_FILTER_EN)
module emf_scheduler
    import EmfPkg::*;
#(
    parameter int NUM_MOT    = 4,
    parameter int TMO_CYC    = 15,
    parameter int FILT_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_MOT-1:0]         chan_en,
    input  logic [CUR_W*NUM_MOT-1:0]   cur_cmd_bus,
    input  logic [CUR_W*NUM_MOT-1:0]   cur_fb_bus,
    output logic                       emf_val_ready,
    output logic [CUR_W-1:0]           emf_cur_cmd,
    output logic [CUR_W-1:0]           emf_cur_fb,
    input  logic                       emf_ready,
    input  logic                       emf_overflow,
    input  logic [EMF_W-1:0]           emf_in,
    output logic [EMF_W*NUM_MOT-1:0]   emf_bus,
    output logic [NUM_MOT-1:0]         ovf_flags,
    output logic [NUM_MOT-1:0]         tmo_flags,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 overrun_cnt
);

    localparam int IDX_W = (NUM_MOT > 1) ? $clog2(NUM_MOT) : 1;
    localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_MOT-1:0]         en_q, en_d, ovf_q, ovf_d, tmo_q, tmo_d;
    logic [CUR_W*NUM_MOT-1:0]   cmd_q, cmd_d, fb_q, fb_d;
    logic [EMF_W*NUM_MOT-1:0]   emf_q, emf_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       pend_q, pend_d;
    logic [7:0]                 ovr_q, ovr_d;
    logic                       begin_pass, advance, ovr_inc;
    logic [IDX_W-1:0]           first_idx, nxt_idx;
    logic                       first_none, nxt_none;

    emf_chan_sel #(.NUM_MOT(NUM_MOT), .IDX_W(IDX_W)) u_first_sel (
        .mask_i(chan_en), .cur_idx_i('0), .incl_cur_i(1'b1),
        .nxt_idx_o(first_idx), .none_left_o(first_none)
    );

    emf_chan_sel #(.NUM_MOT(NUM_MOT), .IDX_W(IDX_W)) u_next_sel (
        .mask_i(en_q), .cur_idx_i(idx_q), .incl_cur_i(1'b0),
        .nxt_idx_o(nxt_idx), .none_left_o(nxt_none)
    );

`ifdef EMF_FILTER_EN
    // The emf_bus slice itself holds the filter state; the raw sample waits in cap_q.
    logic [EMF_W-1:0]        cap_q, cap_d, f_cur, filt_val;
    logic signed [EMF_W:0]   f_diff, f_sum;

    always_comb begin
        f_cur    = emf_q[int'(idx_q)*EMF_W +: EMF_W];
        f_diff   = $signed({cap_q[EMF_W-1], cap_q}) - $signed({f_cur[EMF_W-1], f_cur});
        f_sum    = $signed({f_cur[EMF_W-1], f_cur}) + (f_diff >>> FILT_SHIFT);
        filt_val = sat_emf(f_sum);
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        cmd_d   = cmd_q;
        fb_d    = fb_q;
        emf_d   = emf_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
`ifdef EMF_FILTER_EN
        cap_d   = cap_q;
`endif
        begin_pass    = 1'b0;
        advance       = 1'b0;
        emf_val_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin_pass = start;
            ISSUE: begin
                emf_val_ready = 1'b1;
                busy          = 1'b1;
                cnt_d         = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (emf_ready) begin
`ifdef EMF_FILTER_EN
                    cap_d = emf_in;
`else
                    emf_d[int'(idx_q)*EMF_W +: EMF_W] = emf_in;
`endif
                    state_d = CAPT;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d[idx_q] = 1'b1;
                    advance      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPT: begin
                busy          = 1'b1;
                ovf_d[idx_q]  = emf_overflow;
`ifdef EMF_FILTER_EN
                emf_d[int'(idx_q)*EMF_W +: EMF_W] = filt_val;
`endif
                advance = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                if (pend_q || start) begin
                    begin_pass = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start arriving while a pass owns the unit is queued one deep.
        ovr_inc = start && pend_q && (busy || done);
        ovr_d   = (ovr_inc && (ovr_q != OVR_MAX)) ? ovr_q + 8'd1 : ovr_q;
        if (start && busy && !pend_q) begin
            pend_d = 1'b1;
        end

        if (advance) begin
            if (nxt_none) begin
                state_d = DONE;
            end else begin
                idx_d   = nxt_idx;
                state_d = ISSUE;
            end
        end

        if (begin_pass) begin
            cmd_d   = cur_cmd_bus;
            fb_d    = cur_fb_bus;
            en_d    = chan_en;
            ovf_d   = '0;
            tmo_d   = '0;
            pend_d  = 1'b0;
            idx_d   = first_idx;
            state_d = first_none ? DONE : ISSUE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= '0;
            cmd_q   <= '0;
            fb_q    <= '0;
            emf_q   <= '0;
            ovf_q   <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= '0;
`ifdef EMF_FILTER_EN
            cap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            cmd_q   <= cmd_d;
            fb_q    <= fb_d;
            emf_q   <= emf_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
`ifdef EMF_FILTER_EN
            cap_q   <= cap_d;
`endif
        end
    end

    assign emf_cur_cmd = cmd_q[int'(idx_q)*CUR_W +: CUR_W];
    assign emf_cur_fb  = fb_q[int'(idx_q)*CUR_W +: CUR_W];
    assign emf_bus     = emf_q;
    assign ovf_flags   = ovf_q;
    assign tmo_flags   = tmo_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_emf_scheduler.sv
// tb/tb_emf_scheduler.sv - randomized self-checking bench for emf_scheduler
module tb_emf_scheduler;

    localparam int NM = 4;
    localparam int FS = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    chan_en = '0;
    logic [63:0]   cur_cmd_bus = '0;
    logic [63:0]   cur_fb_bus = '0;
    logic          emf_ready = 1'b0;
    logic          emf_overflow = 1'b0;
    logic [16:0]   emf_in = '0;
    logic          emf_val_ready;
    logic [15:0]   emf_cur_cmd, emf_cur_fb;
    logic [67:0]   emf_bus;
    logic [3:0]    ovf_flags, tmo_flags;
    logic          busy, done;
    logic [7:0]    overrun_cnt;

    emf_scheduler #(.NUM_MOT(NM), .TMO_CYC(15), .FILT_SHIFT(FS)) dut (
        .clk(clk), .reset(reset), .start(start), .chan_en(chan_en),
        .cur_cmd_bus(cur_cmd_bus), .cur_fb_bus(cur_fb_bus),
        .emf_val_ready(emf_val_ready), .emf_cur_cmd(emf_cur_cmd), .emf_cur_fb(emf_cur_fb),
        .emf_ready(emf_ready), .emf_overflow(emf_overflow), .emf_in(emf_in),
        .emf_bus(emf_bus), .ovf_flags(ovf_flags), .tmo_flags(tmo_flags),
        .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state for the current pass
    int          exp_emf [NM];
    logic [15:0] snap_cmd [NM];
    logic [15:0] snap_fb [NM];
    bit          drop [NM];
    bit          ovfp [NM];
    int          val [NM];
    int          exp_q [$];
    int          exp_lat, exp_pulses, n_pulses;
    logic [3:0]  exp_tmo, exp_ovf;
    int          exp_ovr = 0;
    int          cyc = 0;
    int          last_pulse = -100;
    int          last_ch = 0;
    bit          stray = 0;

    function automatic int filt(input int f, input int v);
`ifdef EMF_FILTER_EN
        int s;
        s = f + ((v - f) >>> FS);
        if (s > 65535) s = 65535;
        if (s < -65536) s = -65536;
        return s;
`else
        return v;
`endif
    endfunction

    function automatic logic [67:0] emf_pack();
        logic [67:0] r;
        for (int i = 0; i < NM; i++) r[17*i +: 17] = 17'(exp_emf[i]);
        return r;
    endfunction

    task automatic rand_bus();
        cur_cmd_bus = {$urandom, $urandom};
        cur_fb_bus  = {$urandom, $urandom};
    endtask

    // Plans a pass from the bus values present now (the DUT's snapshot instant).
    task automatic plan_pass(input logic [3:0] mask, input logic [3:0] dm, input logic [3:0] om, input bit dir);
        exp_q.delete();
        exp_lat = 1;
        exp_pulses = 0;
        exp_tmo = '0;
        exp_ovf = '0;
        n_pulses = 0;
        for (int i = 0; i < NM; i++) begin
            snap_cmd[i] = cur_cmd_bus[16*i +: 16];
            snap_fb[i]  = cur_fb_bus[16*i +: 16];
            drop[i] = dm[i];
            ovfp[i] = om[i];
            val[i]  = dir ? 100 * (i + 1) : int'($signed(17'($urandom)));
            if (mask[i]) begin
                exp_q.push_back(i);
                exp_pulses++;
                if (dm[i]) begin
                    exp_lat += 16;
                    exp_tmo[i] = 1'b1;
                end else begin
                    exp_lat += 3;
                    exp_ovf[i] = om[i];
                    exp_emf[i] = filt(exp_emf[i], val[i]);
                end
            end
        end
    endtask

    // Behavioural shared unit: answers one clock after each trigger pulse.
    always @(posedge clk) begin
        bit vr, rdy;
        int ch;
        vr = emf_val_ready;
        rdy = emf_ready;
        cyc++;
        #1;
        emf_ready = stray;
        emf_overflow = 1'($urandom);
        emf_in = 17'($urandom);
        if (rdy) emf_overflow = ovfp[last_ch];
        if (vr) begin
            n_pulses++;
            check_val("pulse_gap", 128'(cyc - last_pulse >= 3), 1);
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                check_val("pulse_unexpected", 1, 0);
            end else begin
                ch = exp_q.pop_front();
                last_ch = ch;
                check_val("issue_cmd", emf_cur_cmd, snap_cmd[ch]);
                check_val("issue_fb", emf_cur_fb, snap_fb[ch]);
                if (!drop[ch]) begin
                    emf_ready = 1'b1;
                    emf_in = 17'(val[ch]);
                end
            end
        end
    end

    // Counts cycles after the sampling edge until done, then checks the results.
    task automatic wait_done(input string tag, input int k0, input bit chk_busy);
        int k;
        k = k0;
        while (k < k0 + 300) begin
            @(negedge clk);
            k++;
            if (k == 1 && chk_busy) check_val({tag, "_busy"}, busy, exp_pulses != 0);
            if (done) break;
        end
        check_val({tag, "_latency"}, k, exp_lat);
        check_val({tag, "_emf_bus"}, emf_bus, emf_pack());
        check_val({tag, "_tmo"}, tmo_flags, exp_tmo);
        check_val({tag, "_ovf"}, ovf_flags, exp_ovf);
        check_val({tag, "_pulses"}, n_pulses, exp_pulses);
        check_val({tag, "_overrun"}, overrun_cnt, exp_ovr);
        check_val({tag, "_busy_done"}, busy, 0);
    endtask

    task automatic do_pass(input string tag, input logic [3:0] mask, input logic [3:0] dm,
                           input logic [3:0] om, input bit dir);
        @(negedge clk);
        rand_bus();
        chan_en = mask;
        start = 1'b1;
        plan_pass(mask, dm, om, dir);
        @(posedge clk);
        #1;
        start = 1'b0;
        chan_en = 4'($urandom);
        rand_bus();
        wait_done(tag, 0, 1'b1);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        for (int i = 0; i < NM; i++) exp_emf[i] = 0;

        repeat (2) @(negedge clk);
        check_val("rst_bus", emf_bus, 0);
        check_val("rst_ctrl", {busy, done, emf_val_ready, ovf_flags, tmo_flags, overrun_cnt}, 0);
        check_val("rst_cmd", {emf_cur_cmd, emf_cur_fb}, 0);
        reset = 1'b1;

        do_pass("all4", 4'hF, 4'h0, 4'h0, 1'b1);
        check_val("all4_vals", emf_bus, {17'd400, 17'd300, 17'd200, 17'd100});
        do_pass("mask0101", 4'b0101, 4'h0, 4'h0, 1'b0);
        do_pass("tmo_ch1", 4'hF, 4'b0010, 4'h0, 1'b0);
        do_pass("ovf_ch3", 4'hF, 4'h0, 4'b1000, 1'b0);
        do_pass("ovf_clear", 4'hF, 4'h0, 4'h0, 1'b0);
        do_pass("mask0", 4'h0, 4'h0, 4'hF, 1'b0);

        // Stray result strobe while idle must be ignored
        @(negedge clk);
        stray = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        stray = 1'b0;
        repeat (2) @(negedge clk);
        check_val("stray_bus", emf_bus, emf_pack());
        check_val("stray_busy", busy, 0);

        // Two starts during a pass: one queued, one counted as overrun
        @(negedge clk);
        rand_bus();
        chan_en = 4'hF;
        start = 1'b1;
        plan_pass(4'hF, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rand_bus();
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        exp_ovr++;
        @(posedge clk);
        #1;
        start = 1'b0;
        rand_bus();
        wait_done("pend1", 4, 1'b0);
        plan_pass(4'hF, 4'b0100, 4'b0001, 1'b0);
        wait_done("pend2", 0, 1'b1);
        @(negedge clk);
        check_val("pend2_done_pulse", done, 0);

        for (int r = 0; r < 12; r++) begin
            logic [3:0] m, dm;
            m = 4'($urandom);
            dm = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            do_pass("rand", m, dm, 4'($urandom), 1'b0);
        end

        // Asynchronous reset in the middle of channel 1's WAIT
        @(negedge clk);
        rand_bus();
        chan_en = 4'hF;
        start = 1'b1;
        plan_pass(4'hF, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("arst_bus", emf_bus, 0);
        check_val("arst_ctrl", {busy, done, emf_val_ready, ovf_flags, tmo_flags, overrun_cnt}, 0);
        check_val("arst_cmd", {emf_cur_cmd, emf_cur_fb}, 0);
        exp_q.delete();
        exp_ovr = 0;
        for (int i = 0; i < NM; i++) exp_emf[i] = 0;
        repeat (2) @(negedge clk);
        check_val("arst_no_done", done, 0);
        reset = 1'b1;
        do_pass("post_rst", 4'hF, 4'h0, 4'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
